// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with a small RX FIFO behind memory-mapped DATA/STATUS registers.
// Optional even-parity framing (8E1) is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_mmio #(
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_ADDR    = 32'h2002,
    parameter logic [31:0] STATUS_ADDR  = 32'h2003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [31:0] addr,
    input  logic        memread,
    output logic [31:0] read_data,
    output logic        rx_valid,
    output logic        overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t        r_state;
    logic          r_rx_m, r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count;
    logic          r_overrun, r_frame_err, r_parity_err;
    logic          r_prev_data, r_prev_stat;
    logic          w_tick, w_par_bad, w_par_set, w_push_req, w_frame_set;
    logic          w_acc_data, w_acc_stat, w_pop, w_clr, w_full, w_push, w_ovr_set;
`ifdef UART_RX_PARITY_EN
    logic          r_par_bad;
    assign w_par_bad = r_par_bad;
    assign w_par_set = (r_state == S_PARITY) && w_tick && (r_rx_s != ^r_shift);
`else
    assign w_par_bad = 1'b0;
    assign w_par_set = 1'b0;
`endif

    assign w_tick      = r_cnt == '0;
    assign w_push_req  = (r_state == S_STOP) && w_tick && r_rx_s && !w_par_bad;
    assign w_frame_set = (r_state == S_STOP) && w_tick && !r_rx_s;
    assign w_acc_data  = memread && (addr == DATA_ADDR);
    assign w_acc_stat  = memread && (addr == STATUS_ADDR);
    assign w_pop       = w_acc_data && !r_prev_data && rx_valid;
    assign w_clr       = w_acc_stat && !r_prev_stat;
    assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovr_set   = w_push_req && w_full && !w_pop;
    assign rx_valid    = r_count != '0;
    assign overrun     = r_overrun;

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    // Frame FSM: mid-bit sampling driven by a down-counter reloaded every bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (!r_rx_s) begin
                    r_state <= S_START;
                    r_cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
                end
                S_START: if (!w_tick) r_cnt <= r_cnt - CW'(1);
                else if (r_rx_s) r_state <= S_IDLE;
                else begin
                    r_state <= S_DATA;
                    r_cnt   <= CW'(CLKS_PER_BIT - 1);
                    r_bit   <= '0;
`ifdef UART_RX_PARITY_EN
                    r_par_bad <= 1'b0;
`endif
                end
                S_DATA: if (!w_tick) r_cnt <= r_cnt - CW'(1);
                else begin
                    r_shift <= {r_rx_s, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                    r_cnt   <= CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
                    if (r_bit == 3'd7) r_state <= S_PARITY;
`else
                    if (r_bit == 3'd7) r_state <= S_STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (!w_tick) r_cnt <= r_cnt - CW'(1);
                else begin
                    r_par_bad <= r_rx_s != ^r_shift;
                    r_cnt     <= CW'(CLKS_PER_BIT - 1);
                    r_state   <= S_STOP;
                end
`endif
                S_STOP: if (!w_tick) r_cnt <= r_cnt - CW'(1);
                else r_state <= r_rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (r_rx_s) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage: written at the stop-bit sample when the push is accepted
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= r_shift;
    end

    // FIFO pointers/count, sticky flags and first-cycle access detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_prev_data  <= 1'b0;
            r_prev_stat  <= 1'b0;
        end else begin
            r_wp         <= r_wp + AW'(w_push);
            r_rp         <= r_rp + AW'(w_pop);
            r_count      <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_overrun    <= w_ovr_set | (r_overrun & ~w_clr);
            r_frame_err  <= w_frame_set | (r_frame_err & ~w_clr);
            r_parity_err <= w_par_set | (r_parity_err & ~w_clr);
            r_prev_data  <= w_acc_data;
            r_prev_stat  <= w_acc_stat;
        end
    end

    // Register read mux; data reads show 0 while the FIFO is empty
    always_comb begin
        read_data = (addr == DATA_ADDR) ? {24'b0, rx_valid ? r_mem[r_rp] : 8'h00} :
                    (addr == STATUS_ADDR) ? {21'b0, 5'(r_count), 1'b0, r_parity_err,
                                             r_frame_err, r_overrun, w_full, rx_valid} : 32'b0;
    end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed self-checking bench for uart_rx_mmio at 16 clocks per bit, 4-entry FIFO.
module tb_uart_rx_mmio;
    localparam int CPB = 16;
    localparam logic [31:0] DA = 32'h2002;
    localparam logic [31:0] SA = 32'h2003;
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_AT = 170;
`else
    localparam int PUSH_AT = 154;
`endif

    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, memread = 1'b0;
    logic [31:0] addr = '0, read_data, d;
    logic        rx_valid, overrun;
    int          n_total = 0, n_bad = 0;

    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DATA_ADDR(DA), .STATUS_ADDR(SA)) dut (
        .clk(clk), .rst(rst), .rx(rx), .addr(addr), .memread(memread),
        .read_data(read_data), .rx_valid(rx_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] v, input logic stop, input logic bad_par);
        @(negedge clk);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(v[i]);
`ifdef UART_RX_PARITY_EN
        bit_out(^v ^ bad_par);
`endif
        if (stop) bit_out(1'b1);
        else rx = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] q);
        @(negedge clk);
        addr = a;
        memread = 1'b1;
        #1 q = read_data;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        memread = 1'b0;
        addr = '0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset overrun", overrun, 0);
        rd(SA, 1, d); chk("reset status", d, 0);
        rd(DA, 1, d); chk("empty data", d, 0);

        send(8'h55, 1, 0);
        chk("t1 valid", rx_valid, 1);
        rd(DA, 1, d); chk("t1 data", d, 32'h55);
        chk("t1 valid after pop", rx_valid, 0);
        rd(SA, 1, d); chk("t1 status", d, 0);

        send(8'h01, 1, 0); send(8'h80, 1, 0); send(8'hFF, 1, 0); send(8'h3C, 1, 0);
        rd(SA, 1, d); chk("t2 full status", d, 32'h103);
        send(8'hA5, 1, 0);
        chk("t2 overrun", overrun, 1);
        rd(DA, 1, d); chk("t2 rd0", d, 32'h01);
        rd(DA, 1, d); chk("t2 rd1", d, 32'h80);
        rd(DA, 1, d); chk("t2 rd2", d, 32'hFF);
        rd(DA, 1, d); chk("t2 rd3", d, 32'h3C);
        rd(SA, 1, d); chk("t2 status ovr", d, 32'h004);
        chk("t2 overrun cleared", overrun, 0);

        @(negedge clk); rx = 1'b0;
        repeat (5) @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        rd(SA, 1, d); chk("t3 glitch status", d, 0);

        send(8'h0F, 0, 0);
        repeat (100 * CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rd(SA, 1, d); chk("t4 frame_err", d, 32'h008);
        rd(SA, 1, d); chk("t4 cleared", d, 0);
        send(8'h42, 1, 0);
        rd(DA, 1, d); chk("t4 after break", d, 32'h42);

        send(8'h11, 1, 0); send(8'h22, 1, 0);
        rd(SA, 1, d); chk("t5 count2", d, 32'h081);
        rd(DA, 3, d); chk("t5 held read", d, 32'h11);
        rd(SA, 1, d); chk("t5 count1", d, 32'h041);
        rd(DA, 1, d); chk("t5 second", d, 32'h22);

        send(8'h0A, 1, 0); send(8'h0B, 1, 0); send(8'h0C, 1, 0); send(8'h0D, 1, 0);
        fork
            send(8'h0E, 1, 0);
            begin
                @(negedge rx);
                repeat (PUSH_AT) @(posedge clk);
                rd(DA, 1, d); chk("t5 pop at push", d, 32'h0A);
            end
        join
        chk("t5 no overrun", overrun, 0);
        rd(SA, 1, d); chk("t5 still full", d, 32'h103);
        rd(DA, 1, d); chk("t5 q0", d, 32'h0B);
        rd(DA, 1, d); chk("t5 q1", d, 32'h0C);
        rd(DA, 1, d); chk("t5 q2", d, 32'h0D);
        rd(DA, 1, d); chk("t5 q3", d, 32'h0E);

        send(8'h77, 1, 0);
        chk("t6 preload", rx_valid, 1);
        fork
            send(8'h5A, 1, 0);
            begin
                @(negedge rx);
                repeat (80) @(posedge clk);
                @(negedge clk); rst = 1'b1;
                @(negedge clk);
                addr = SA;
                #1;
                chk("t6 rst valid", rx_valid, 0);
                chk("t6 rst overrun", overrun, 0);
                chk("t6 rst status", read_data, 0);
                addr = '0;
            end
        join
        @(negedge clk); rst = 1'b0;
        rd(SA, 1, d); chk("t6 status after rst", d, 0);
        send(8'h99, 1, 0);
        rd(DA, 1, d); chk("t6 after rst rx", d, 32'h99);
`ifdef UART_RX_PARITY_EN
        send(8'h07, 1, 1);
        rd(SA, 1, d); chk("t6 parity_err", d, 32'h010);
        chk("t6 parity no push", rx_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
